btn_sw_debounce: RTL and testbench
==================================

Name: btn_sw_debounce

Overview:
- Conditions raw board buttons/switches before they reach the clock divider and CPU-clock select logic.
- Synchronises N asynchronous inputs into the `clk` domain and filters bounce with a per-channel stability counter.
- Outputs clean levels, e.g. the clock-select switch and the reset button fed to the divider, plus one-cycle rise and fall pulses for single-step and edge-triggered logic.
- Sits directly upstream of the clock divider and runs on the raw board clock.

Parameters:
- N_CH, 8: number of independent input channels.
- DB_CYCLES, 1000000: consecutive stable cycles required before a level change is accepted (10 ms at 100 MHz). Must be ≥ 1.
- CNT_W, 20: counter width. Must satisfy 2^CNT_W > DB_CYCLES-1.
- RST_VAL, 0: N_CH-bit reset value of the synchroniser and debounced level.

Ports:
- clk  input  1  board clock; all logic on posedge.
- rst  input  1  reset, synchronous and active-low (0 = reset, sampled on posedge clk).
- raw_i  input  N_CH  asynchronous button/switch levels.
- db_o  output  N_CH  debounced level per channel.
- rise_o  output  N_CH  one-cycle pulse when db_o[k] goes 0→1.
- fall_o  output  N_CH  one-cycle pulse when db_o[k] goes 1→0.

Behaviour:
- Reset (rst==0 at a posedge):
  - sync1, sync2 and db_o load RST_VAL.
  - All counters load 0.
  - rise_o and fall_o load 0.
  - Reset wins over every other event, including mid-count and on a pulse cycle.
- Synchroniser: per channel, sync1 <= raw_i[k], then sync2 <= sync1. No other logic reads raw_i.
- Per-channel update at each posedge (rst==1):
  - STABLE (sync2 == db_o[k]): cnt <= 0; rise/fall <= 0.
  - COUNTING (sync2 != db_o[k], cnt < DB_CYCLES-1): cnt <= cnt+1; rise/fall <= 0.
  - ACCEPT (sync2 != db_o[k], cnt == DB_CYCLES-1): db_o[k] <= sync2; cnt <= 0; rise_o[k] <= sync2; fall_o[k] <= ~sync2.
- Latency: a clean raw step just before edge 1 changes db_o and asserts the pulse at edge DB_CYCLES+2. All three outputs are registered.
- Glitch rejection: any return of sync2 to db_o before ACCEPT clears cnt. A bounce restarts the full DB_CYCLES window, and no output changes.
- Pulses are exactly one cycle wide. The next ACCEPT on the same channel is at least DB_CYCLES cycles later, so pulses never merge.
- DB_CYCLES==1: db_o follows sync2 with one cycle of delay, and a pulse accompanies every change.
- Counter arithmetic is unsigned CNT_W bits. It never reaches DB_CYCLES, so no wrap occurs.
- Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses.
- Releasing rst: the first non-reset edge compares against RST_VAL. A raw level that differs from RST_VAL is accepted after DB_CYCLES+2 edges, with the matching pulse.

Decomposition:
- Shared package holds:
  - CNT_W derivation helper (clog2 of DB_CYCLES).
  - Default DB_CYCLES constant for the board clock.
  - Named channel-index constants (clock-select switch, reset button, step button).
- Sub-module debounce_channel holds one channel's synchroniser, counter, level and pulse logic.
- Top level is a generate loop of N_CH debounce_channel instances.

Test Plan:
- Reset: DB_CYCLES=4, RST_VAL=0, raw_i=8'hFF, rst=0 for 3 cycles -> db_o=0, rise_o=0, fall_o=0, counters 0 throughout.
- Clean step: raw_i[0] goes 0→1 before edge 1 -> db_o[0]=1 and rise_o[0]=1 at edge 6, rise_o[0]=0 at edge 7, other bits unchanged.
- Bounce: raw_i[1] toggles 1,0,1,0 each cycle then holds 1 -> db_o[1] rises exactly 6 edges after the final 0→1 transition, with a single rise pulse.
- Short glitch: raw_i[2] high for 3 cycles then low -> db_o[2] stays 0, no pulses.
- Release and multi-channel: from db_o=8'h03, raw_i=8'h00 and raw_i[7]=1 simultaneously -> at the same edge db_o=8'h80, fall_o=8'h03, rise_o=8'h80.
- Reset mid-count: rst=0 while raw_i[3]=1 with cnt=2 -> db_o[3]=0 and cnt=0; after release the full 6-edge latency applies again.

Source files
------------

// File: rtl/btn_sw_debounce_pkg.sv
// Shared constants and helpers for the board button/switch debouncer.
package btn_sw_debounce_pkg;

  // 10 ms stability window at the 100 MHz board clock.
  localparam int unsigned DB_CYCLES_DEFAULT = 1_000_000;

  localparam int unsigned CH_CLK_SEL  = 0;
  localparam int unsigned CH_RST_BTN  = 1;
  localparam int unsigned CH_STEP_BTN = 2;

  // Smallest counter width able to hold DB_CYCLES-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned db_cycles);
    return (db_cycles <= 2) ? 1 : $clog2(db_cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: two-flop synchroniser, stability counter,
// accepted level and one-cycle rise/fall pulses.
module debounce_channel
  import btn_sw_debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W     = cnt_width(DB_CYCLES),
  parameter logic        RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  logic             w_db_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // A differing level must persist DB_CYCLES compares in a row to be accepted.
  always_comb begin
    w_cnt_nxt  = '0;
    w_db_nxt   = r_db;
    w_rise_nxt = 1'b0;
    w_fall_nxt = 1'b0;
    if (r_sync2 != r_db) begin
      if (r_cnt == CNT_LAST) begin
        w_db_nxt   = r_sync2;
        w_rise_nxt = r_sync2;
        w_fall_nxt = ~r_sync2;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
      r_db    <= RST_VAL;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= raw_i;
      r_sync2 <= r_sync1;
      r_db    <= w_db_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign db_o   = r_db;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule

// File: rtl/btn_sw_debounce.sv
// Debounces N_CH raw board buttons/switches into clean levels and edge pulses
// ahead of the clock divider and CPU-clock select.
module btn_sw_debounce
  import btn_sw_debounce_pkg::*;
#(
  parameter int unsigned      N_CH      = 8,
  parameter int unsigned      DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned      CNT_W     = cnt_width(DB_CYCLES),
  parameter logic [N_CH-1:0]  RST_VAL   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_i,
  output logic [N_CH-1:0] db_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W),
      .RST_VAL   (RST_VAL[k])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw_i[k]),
      .db_o   (db_o[k]),
      .rise_o (rise_o[k]),
      .fall_o (fall_o[k])
    );
  end

endmodule

// File: tb/tb_btn_sw_debounce.sv
// Scoreboard bench: a sliding-window reference model predicts db/rise/fall per edge.
module tb_btn_sw_debounce;

  localparam int unsigned N_CH    = 8;
  localparam int unsigned DB      = 4;
  localparam logic [7:0]  RST_VAL = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] raw_i = 8'hFF;
  logic [7:0] db_o, rise_o, fall_o;

  typedef struct packed {
    logic [7:0] db;
    logic [7:0] rise;
    logic [7:0] fall;
  } exp_t;

  exp_t       exp_q[$];
  logic       rec_rst[$];
  logic [7:0] rec_raw[$];
  logic [7:0] m_db = RST_VAL;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         active = 1'b0;

  btn_sw_debounce #(
    .N_CH      (N_CH),
    .DB_CYCLES (DB),
    .RST_VAL   (RST_VAL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (raw_i),
    .db_o   (db_o),
    .rise_o (rise_o),
    .fall_o (fall_o)
  );

  always #5 clk = ~clk;

  // Level the design sees for channel k at edge t: raw from two edges back,
  // or the reset value if either of the two intervening edges was a reset.
  function automatic logic seen_at(input int t, input int k);
    logic [7:0] rv;
    rv = RST_VAL;
    if (t < 2) return rv[k];
    if (!rec_rst[t-1] || !rec_rst[t-2]) return rv[k];
    return rec_raw[t-2][k];
  endfunction

  // Accept at edge t when the last DB seen levels all differ from the current
  // level and no reset falls inside that window.
  task automatic model_edge();
    int         t;
    logic [7:0] nd;
    exp_t       e;
    bit         acc;
    t = rec_rst.size() - 1;
    e = '0;
    if (!rec_rst[t]) begin
      m_db   = RST_VAL;
      e.db   = RST_VAL;
    end else begin
      nd = m_db;
      for (int k = 0; k < int'(N_CH); k++) begin
        acc = 1'b1;
        for (int j = 0; j < int'(DB); j++) begin
          if (t - j < 0) acc = 1'b0;
          else if (!rec_rst[t-j] || seen_at(t - j, k) == m_db[k]) acc = 1'b0;
        end
        if (acc) begin
          nd[k]     = ~m_db[k];
          e.rise[k] = nd[k];
          e.fall[k] = ~nd[k];
        end
      end
      m_db = nd;
      e.db = nd;
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [7:0] v);
    @(negedge clk);
    rst   = r;
    raw_i = v;
    rec_rst.push_back(r);
    rec_raw.push_back(v);
    model_edge();
    active = 1'b1;
  endtask

  task automatic hold(input logic r, input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) step(r, v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: every edge after stimulus starts must match the next prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (active) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty at %0t: got no prediction, expected one", $time);
      end else begin
        e = exp_q.pop_front();
        check("db_o", db_o, e.db);
        check("rise_o", rise_o, e.rise);
        check("fall_o", fall_o, e.fall);
      end
    end
  end

  initial begin
    logic [7:0] r_raw;
    logic [7:0] flip;
    hold(1'b0, 8'hFF, 3);                       // reset with all inputs high
    hold(1'b1, 8'h00, 4);
    hold(1'b1, 8'h01, 10);                      // clean step on ch0
    step(1'b1, 8'h03); step(1'b1, 8'h01);       // bounce on ch1
    step(1'b1, 8'h03); step(1'b1, 8'h01);
    hold(1'b1, 8'h03, 10);
    hold(1'b1, 8'h07, 3);                       // short glitch on ch2
    hold(1'b1, 8'h03, 10);
    hold(1'b1, 8'h80, 10);                      // release ch0/ch1, press ch7
    hold(1'b1, 8'h88, 4);                       // reset mid-count on ch3
    step(1'b0, 8'h88);
    hold(1'b1, 8'h88, 10);
    r_raw = 8'h88;
    for (int i = 0; i < 3000; i++) begin
      flip = '0;
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, 5) == 0) flip[k] = 1'b1;
      r_raw = r_raw ^ flip;
      step(($urandom_range(0, 299) != 0), r_raw);
    end
    @(negedge clk);
    active = 1'b0;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
